// File: rtl/beta_prefetch_buffer_if.sv
// Bus bundle for the instruction prefetch buffer.
// Groups the memory-side request/response port and the fetch-stage handshake.
// The master view belongs to the prefetch buffer; the slave view belongs to
// the surrounding memory and fetch stage.
interface beta_prefetch_buffer_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  // control from the pipeline
  logic                 pf_fetch_en_i;
  logic                 pf_flush_i;
  logic [AddrWidth-1:0] pf_flush_addr_i;
  // instruction memory port
  logic                 pf_instr_req_o;
  logic [AddrWidth-1:0] pf_instr_addr_o;
  logic                 pf_instr_ready_i;
  logic                 pf_instr_valid_i;
  logic [DataWidth-1:0] pf_instr_rdata_i;
  // fetch-stage port
  logic                 pf_valid_o;
  logic [DataWidth-1:0] pf_instr_o;
  logic [AddrWidth-1:0] pf_pc_o;
  logic                 pf_ready_i;
  logic                 pf_empty_o;
  logic                 pf_full_o;

  modport master (
    input  pf_fetch_en_i, pf_flush_i, pf_flush_addr_i,
    input  pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i,
    input  pf_ready_i,
    output pf_instr_req_o, pf_instr_addr_o,
    output pf_valid_o, pf_instr_o, pf_pc_o, pf_empty_o, pf_full_o
  );

  modport slave (
    output pf_fetch_en_i, pf_flush_i, pf_flush_addr_i,
    output pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i,
    output pf_ready_i,
    input  pf_instr_req_o, pf_instr_addr_o,
    input  pf_valid_o, pf_instr_o, pf_pc_o, pf_empty_o, pf_full_o
  );
endinterface

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer.
// Issues sequential fetches ahead of the fetch stage, keeps returned words with
// their PC in an in-order FIFO, and on a flush drops the buffered words and any
// stale in-flight responses before restarting at the new target.
module beta_prefetch_buffer #(
  parameter int                   DataWidth      = 32,
  parameter int                   AddrWidth      = 32,
  parameter int                   Depth          = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = '0
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  beta_prefetch_buffer_if.master bus
);

  localparam int PtrW  = $clog2(Depth);
  localparam int CntW  = PtrW + 1;
  localparam int PendW = $clog2(MaxOutstanding + 1);

  localparam logic [CntW:0]      DepthOcc = (CntW + 1)'(Depth);
  localparam logic [CntW-1:0]    DepthCnt = CntW'(Depth);
  localparam logic [PendW-1:0]   MaxOut   = PendW'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] WordInc  = AddrWidth'(4);
  localparam logic [AddrWidth-1:0] AlignMsk = {{(AddrWidth - 2){1'b1}}, 2'b00};

  logic [AddrWidth-1:0] fetch_addr;
  logic [AddrWidth-1:0] resp_pc;
  logic [CntW-1:0]      wptr;
  logic [CntW-1:0]      rptr;
  logic [CntW-1:0]      count;
  logic [PendW-1:0]     pending;
  logic [PendW-1:0]     discard;
  logic [DataWidth-1:0] instr_mem [Depth];
  logic [AddrWidth-1:0] pc_mem    [Depth];

  logic                 flush;
  logic                 grant;
  logic                 resp;
  logic                 resp_dec;
  logic                 drop;
  logic                 push;
  logic                 pop;
  logic [CntW:0]        occupancy;
  logic [AddrWidth-1:0] flush_target;

  assign flush        = bus.pf_flush_i;
  assign flush_target = bus.pf_flush_addr_i & AlignMsk;

  // Buffered words plus words already in flight must fit in the FIFO, so a
  // request is only issued when its response is guaranteed a slot.
  assign occupancy = {1'b0, count} + (CntW + 1)'(pending);

  assign bus.pf_instr_req_o  = bus.pf_fetch_en_i & ~flush &
                               (occupancy < DepthOcc) & (pending < MaxOut);
  assign bus.pf_instr_addr_o = fetch_addr;

  assign grant    = bus.pf_instr_req_o & bus.pf_instr_ready_i;
  assign resp     = bus.pf_instr_valid_i;
  assign resp_dec = resp & (pending != '0);
  assign drop     = resp & (discard != '0);
  assign push     = resp & ~drop & ~flush;
  assign pop      = (count != '0) & bus.pf_ready_i;

  assign bus.pf_valid_o = (count != '0);
  assign bus.pf_instr_o = instr_mem[rptr[PtrW-1:0]];
  assign bus.pf_pc_o    = pc_mem[rptr[PtrW-1:0]];
  assign bus.pf_empty_o = (count == '0);
  assign bus.pf_full_o  = (count == DepthCnt);

  // Request address, response PC and in-flight bookkeeping; a flush retargets
  // both address streams and marks every still-unanswered request as stale.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_addr <= BootAddr;
      resp_pc    <= BootAddr;
      pending    <= '0;
      discard    <= '0;
    end else begin
      pending <= pending + PendW'(grant) - PendW'(resp_dec);
      if (flush) begin
        fetch_addr <= flush_target;
        resp_pc    <= flush_target;
        discard    <= pending - PendW'(resp_dec);
      end else begin
        if (grant) fetch_addr <= fetch_addr + WordInc;
        if (push)  resp_pc    <= resp_pc + WordInc;
        if (drop)  discard    <= discard - PendW'(1);
      end
    end
  end

  // FIFO pointers and fill level; a flush empties the queue outright.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + CntW'(1);
      if (pop)  rptr <= rptr + CntW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // FIFO storage: each accepted response is written with the PC it belongs to.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < Depth; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wptr[PtrW-1:0]] <= bus.pf_instr_rdata_i;
      pc_mem[wptr[PtrW-1:0]]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Testbench for beta_prefetch_buffer: directed scenarios plus randomized traffic
// against a transaction-level model (queue of expected words, queue of in-flight
// memory reads tagged with a flush epoch).
module tb_beta_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic rstn;

  beta_prefetch_buffer_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  beta_prefetch_buffer #(
    .DataWidth(32), .AddrWidth(32), .Depth(DEPTH),
    .MaxOutstanding(MAXO), .BootAddr(32'h0)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model state
  mreq_t       mq[$];
  ent_t        fq[$];
  logic [31:0] popped[$];
  logic [31:0] grant_log[$];
  logic [31:0] fa;
  int          epoch;
  int          cyc;
  int          lat_lo;
  int          lat_hi;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_regs();
    chk("valid", bus.pf_valid_o, fq.size() != 0);
    chk("empty", bus.pf_empty_o, fq.size() == 0);
    chk("full", bus.pf_full_o, fq.size() == DEPTH);
    if (fq.size() != 0) begin
      chk("instr", bus.pf_instr_o, fq[0].instr);
      chk("pc", bus.pf_pc_o, fq[0].pc);
    end
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_req"}, bus.pf_instr_req_o, 32'd0);
    chk({tag, "_addr"}, bus.pf_instr_addr_o, 32'h0);
    chk({tag, "_valid"}, bus.pf_valid_o, 32'd0);
    chk({tag, "_instr"}, bus.pf_instr_o, 32'h0);
    chk({tag, "_pc"}, bus.pf_pc_o, 32'h0);
    chk({tag, "_empty"}, bus.pf_empty_o, 32'd1);
    chk({tag, "_full"}, bus.pf_full_o, 32'd0);
  endtask

  task automatic idle_inputs();
    bus.pf_fetch_en_i    = 1'b0;
    bus.pf_flush_i       = 1'b0;
    bus.pf_flush_addr_i  = '0;
    bus.pf_instr_ready_i = 1'b0;
    bus.pf_instr_valid_i = 1'b0;
    bus.pf_instr_rdata_i = '0;
    bus.pf_ready_i       = 1'b0;
  endtask

  // One clock cycle: called and returning at a falling edge.
  task automatic step(input logic fen, input logic fl, input logic [31:0] fla,
                      input logic rdy, input logic mrdy);
    logic exp_req;
    logic grant;
    logic resp;
    mreq_t r;
    check_regs();
    bus.pf_fetch_en_i    = fen;
    bus.pf_flush_i       = fl;
    bus.pf_flush_addr_i  = fla;
    bus.pf_ready_i       = rdy;
    bus.pf_instr_ready_i = mrdy;
    resp = (mq.size() != 0) && (mq[0].due <= cyc);
    bus.pf_instr_valid_i = resp;
    bus.pf_instr_rdata_i = resp ? mq[0].data : $urandom;
    exp_req = fen && !fl && (fq.size() + mq.size() < DEPTH) && (mq.size() < MAXO);
    #1;
    chk("req", bus.pf_instr_req_o, exp_req);
    chk("addr", bus.pf_instr_addr_o, fa);
    grant = exp_req && mrdy;
    @(posedge clk);
    if (fl) begin
      fq.delete();
      if (resp) void'(mq.pop_front());
      fa = {fla[31:2], 2'b00};
      epoch++;
    end else begin
      if (fq.size() != 0 && rdy) begin
        popped.push_back(fq[0].pc);
        void'(fq.pop_front());
      end
      if (resp) begin
        r = mq.pop_front();
        if (r.epoch == epoch) fq.push_back('{instr: r.data, pc: r.addr});
      end
      if (grant) begin
        mq.push_back('{addr: fa, data: $urandom, epoch: epoch,
                       due: cyc + $urandom_range(lat_hi, lat_lo)});
        grant_log.push_back(fa);
        fa = fa + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fq.size() == 0 && mq.size() == 0) begin
        done = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    chk("drain_done", done, 32'd1);
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    idle_inputs();
    #1;
    reset_literals(tag);
    mq.delete();
    fq.delete();
    fa = 32'h0;
    epoch++;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int g0;
    int p0;
    logic [31:0] fla;
    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    epoch  = 0;
    fa     = 32'h0;
    lat_lo = 1;
    lat_hi = 1;
    rstn   = 1'b0;
    idle_inputs();
    #1;
    reset_literals("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // sequential streaming, 1-cycle memory
    g0 = grant_log.size();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stream_grants", grant_log.size() - g0, 32'd12);
    chk("stream_pc0", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h0);
    chk("stream_pc1", (popped.size() > 1) ? popped[1] : 32'hDEAD_BEEF, 32'h4);
    chk("stream_pc2", (popped.size() > 2) ? popped[2] : 32'hDEAD_BEEF, 32'h8);
    drain();

    // fetch stage stalled: fill to Depth, then a single pop frees one slot
    g0 = grant_log.size();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_grants", grant_log.size() - g0, 32'd4);
    chk("stall_full", bus.pf_full_o, 32'd1);
    g0 = grant_log.size();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("one_pop_grants", grant_log.size() - g0, 32'd1);
    drain();

    // 3-cycle memory: outstanding limit throttles requests
    lat_lo = 3;
    lat_hi = 3;
    g0 = grant_log.size();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("lat3_grants4", grant_log.size() - g0, 32'd2);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("lat3_grants5", grant_log.size() - g0, 32'd3);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    drain();

    // flush with two in flight, one returning in the flush cycle
    lat_lo = 2;
    lat_hi = 2;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("pre_flush_inflight", mq.size(), 32'd2);
    p0 = popped.size();
    g0 = grant_log.size();
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_first_pc", (popped.size() > p0) ? popped[p0] : 32'hDEAD_BEEF, 32'h100);
    chk("flush_first_req", (grant_log.size() > g0) ? grant_log[g0] : 32'hDEAD_BEEF, 32'h100);

    // unaligned flush target and address wrap
    g0 = grant_log.size();
    step(1'b1, 1'b1, 32'h103, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("align_req", (grant_log.size() > g0) ? grant_log[g0] : 32'hDEAD_BEEF, 32'h100);
    g0 = grant_log.size();
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_req0", (grant_log.size() > g0) ? grant_log[g0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_req1", (grant_log.size() > g0 + 1) ? grant_log[g0 + 1] : 32'hDEAD_BEEF, 32'h0);
    drain();

    // asynchronous reset with words buffered and reads in flight
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    async_reset("midrst");
    lat_lo = 1;
    lat_hi = 1;
    g0 = grant_log.size();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("post_rst_req", (grant_log.size() > g0) ? grant_log[g0] : 32'hDEAD_BEEF, 32'h0);

    // randomized traffic
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("rndrst");
      fla = $urandom;
      if ($urandom_range(0, 3) == 0) fla[31:4] = '1;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, fla,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
